conv_lut_bitplane_seq: RTL and testbench

Sequencer for the 4-input/2-output bit-level conv LUT. It accepts four DATA_W-bit activations and presents one bit-plane per cycle to the LUT on lut_bit1..lut_bit4, LSB plane first. It shift-accumulates the 2-bit LUT result into a signed/unsigned dot-product and returns the sum over a valid/ready handshake. The LUT sits outside this block and is purely combinational.

---
 rtl/conv_lut_bitplane_seq.sv | 130 +++++++++++++
 tb/tb_conv_lut_bitplane_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/conv_lut_bitplane_seq.sv
// Bit-plane sequencer for a 4-input/2-output combinational conv LUT.
// Ports: in_valid/in_ready/act_in/signed_mode accept an activation set;
//        lut_bit1..4 drive the current plane to the LUT, lut_dout1/2 return
//        its 2-bit value; out_valid/out_ready/out_acc return the sum; busy
//        is high while an operation is in flight.
module conv_lut_bitplane_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 11,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DATA_W-1:0]   act_in,
    input  logic                  signed_mode,
    output logic                  lut_bit1,
    output logic                  lut_bit2,
    output logic                  lut_bit3,
    output logic                  lut_bit4,
    input  logic                  lut_dout1,
    input  logic                  lut_dout2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_acc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    plane_q, plane_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    res_q, res_d;
    logic [4*DATA_W-1:0] act_q, act_d;
    logic                sgn_q, sgn_d;

    logic [DATA_W-1:0]   a0, a1, a2, a3;
    logic [1:0]          lut_v;
    logic                last;
    logic                run;
    logic [ACC_W-1:0]    term;
    logic [ACC_W-1:0]    acc_nx;

    assign a0    = act_q[DATA_W-1:0];
    assign a1    = act_q[2*DATA_W-1:DATA_W];
    assign a2    = act_q[3*DATA_W-1:2*DATA_W];
    assign a3    = act_q[4*DATA_W-1:3*DATA_W];
    assign lut_v = {lut_dout2, lut_dout1};
    assign last  = (plane_q == CNT_W'(DATA_W - 1));
    assign run   = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        acc_d   = acc_q;
        res_d   = res_q;
        act_d   = act_q;
        sgn_d   = sgn_q;
        term    = ACC_W'(lut_v) << plane_q;
        // Two's-complement MSB plane carries negative weight.
        if (last && sgn_q) begin
            acc_nx = acc_q - term;
        end else begin
            acc_nx = acc_q + term;
        end
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    act_d   = act_in;
                    sgn_d   = signed_mode;
                    acc_d   = '0;
                    plane_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_nx;
                plane_d = plane_q + 1'b1;
                if (last) begin
                    // Separate result register keeps out_acc stable
                    // while the next operation accumulates.
                    res_d   = acc_nx;
                    plane_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            plane_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            act_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            act_q   <= act_d;
            sgn_q   <= sgn_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_acc   = res_q;
    assign lut_bit1  = run & a0[plane_q];
    assign lut_bit2  = run & a1[plane_q];
    assign lut_bit3  = run & a2[plane_q];
    assign lut_bit4  = run & a3[plane_q];

endmodule

// File: tb/tb_conv_lut_bitplane_seq.sv
// Self-checking bench for conv_lut_bitplane_seq with a popcount LUT model.
// Directed test-plan cases plus randomized operations against a reference.
module tb_conv_lut_bitplane_seq;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 11;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       act_in;
    logic              signed_mode;
    logic              lut_bit1, lut_bit2, lut_bit3, lut_bit4;
    logic              lut_dout1, lut_dout2;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_lut_bitplane_seq #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .act_in     (act_in),
        .signed_mode(signed_mode),
        .lut_bit1   (lut_bit1),
        .lut_bit2   (lut_bit2),
        .lut_bit3   (lut_bit3),
        .lut_bit4   (lut_bit4),
        .lut_dout1  (lut_dout1),
        .lut_dout2  (lut_dout2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .busy       (busy)
    );

    // LUT model: v = min(popcount(bits), 3)
    logic [2:0] pc;
    logic [1:0] lv;
    assign pc = 3'(lut_bit1) + 3'(lut_bit2) + 3'(lut_bit3) + 3'(lut_bit4);
    assign lv = (pc > 3'd3) ? 2'd3 : pc[1:0];
    assign lut_dout1 = lv[0];
    assign lut_dout2 = lv[1];

    // Weighted sum of per-plane LUT values, MSB weight negative if signed.
    function automatic logic [ACC_W-1:0] ref_acc(logic [31:0] a, logic s);
        int sum = 0;
        for (int j = 0; j < DATA_W; j++) begin
            int c = int'(a[j]) + int'(a[8+j]) + int'(a[16+j]) + int'(a[24+j]);
            int v = (c > 3) ? 3 : c;
            int w = (s && j == DATA_W - 1) ? -(1 << j) : (1 << j);
            sum += v * w;
        end
        return ACC_W'(sum);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; hold = cycles of out_ready=0 in DONE.
    task automatic run_op(logic [31:0] a, logic s, int hold);
        logic [ACC_W-1:0] exp_acc;
        exp_acc = ref_acc(a, s);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        act_in      = a;
        signed_mode = s;
        out_ready   = (hold == 0);
        step();
        for (int p = 0; p < DATA_W; p++) begin
            // Scramble inputs during RUN; they must be ignored.
            act_in      = $urandom;
            signed_mode = 1'($urandom);
            in_valid    = 1'($urandom);
            chk("run_bits",
                32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}),
                32'({a[24+p], a[16+p], a[8+p], a[p]}));
            chk("run_flags",
                32'({busy, in_ready, out_valid}), 32'b100);
            step();
        end
        in_valid = 1'b1;
        chk("done_valid", 32'(out_valid), 32'd1);
        chk("done_acc", 32'(out_acc), 32'(exp_acc));
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_flags",
                32'({out_valid, in_ready, busy}), 32'b101);
            chk("hold_acc", 32'(out_acc), 32'(exp_acc));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_flags",
            32'({out_valid, in_ready, busy}), 32'b010);
        chk("post_acc", 32'(out_acc), 32'(exp_acc));
        chk("post_bits",
            32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        act_in      = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", 32'(out_acc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bits",
            32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(32'hFFFF_FFFF, 1'b0, 0);
        chk("ff_unsigned", 32'(ref_acc(32'hFFFF_FFFF, 1'b0)), 32'h2FD);
        run_op(32'hFFFF_FFFF, 1'b1, 0);
        chk("ff_signed", 32'(out_acc), 32'h7FD);
        run_op(32'h0804_0201, 1'b0, 0);
        chk("onehot", 32'(out_acc), 32'd15);
        run_op(32'h1234_ABCD, 1'b1, 5);

        // Reset mid-RUN at plane 4.
        in_valid = 1'b1;
        act_in   = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_flags",
            32'({in_ready, out_valid, busy}), 32'b100);
        chk("midrst_acc", 32'(out_acc), 32'd0);
        chk("midrst_bits",
            32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op(32'h0101_0101, 1'b0, 0);
        chk("after_rst", 32'(out_acc), 32'd3);

        // Idle hygiene.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle",
                32'({lut_bit4, lut_bit3, lut_bit2, lut_bit1,
                     busy, out_valid, in_ready}), 32'b0000001);
        end

        // Randomized operations.
        for (int n = 0; n < 30; n++) begin
            run_op($urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
